// File: rtl/cdu_pulse_gen.sv
// CDU increment pulse generator: accumulates signed counts and meters them out as CDUP/CDUM pulses.
// Define CDU_PULSE_OVF_EN to add the sticky saturation flag port ovf.
module cdu_pulse_gen #(
    parameter int CNT_W     = 8,
    parameter int PULSE_W   = 4,
    parameter int GAP_SLOTS = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    slot_tick,
    input  logic                    inc_up,
    input  logic                    inc_dn,
    input  logic                    zero,
    output logic                    CDUP,
    output logic                    CDUM,
    output logic signed [CNT_W-1:0] pending,
    output logic                    busy
`ifdef CDU_PULSE_OVF_EN
    ,
    output logic                    ovf
`endif
);

    localparam int WW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
    localparam int SW = (GAP_SLOTS > 1) ? $clog2(GAP_SLOTS) : 1;
    localparam logic [WW-1:0] WLAST = WW'(PULSE_W - 1);
    localparam logic [SW-1:0] SLAST = SW'(GAP_SLOTS - 1);

    localparam logic signed [CNT_W+1:0] ONE   = {{(CNT_W+1){1'b0}}, 1'b1};
    localparam logic signed [CNT_W+1:0] MAX_S = {3'b000, {(CNT_W-1){1'b1}}};
    localparam logic signed [CNT_W+1:0] MIN_S = -MAX_S;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [WW-1:0]           wcnt, wcnt_nxt;
    logic [SW-1:0]           scnt, scnt_nxt;
    logic                    pol, pol_nxt;
    logic                    launch;
    logic signed [CNT_W+1:0] step, sum;
    logic signed [CNT_W-1:0] pending_nxt;
    logic                    sat_hi, sat_lo;

    always_comb begin
        state_nxt   = state;
        wcnt_nxt    = wcnt;
        scnt_nxt    = scnt;
        pol_nxt     = pol;
        launch      = 1'b0;
        step        = '0;
        sum         = '0;
        sat_hi      = 1'b0;
        sat_lo      = 1'b0;
        pending_nxt = pending;

        unique case (state)
            IDLE: begin
                if (slot_tick && !zero && (pending != '0)) begin
                    launch    = 1'b1;
                    pol_nxt   = ~pending[CNT_W-1];
                    wcnt_nxt  = '0;
                    state_nxt = PULSE;
                end
            end
            PULSE: begin
                if (wcnt == WLAST) begin
                    wcnt_nxt  = '0;
                    scnt_nxt  = '0;
                    state_nxt = GAP;
                end else begin
                    wcnt_nxt = wcnt + 1'b1;
                end
            end
            GAP: begin
                if (slot_tick) begin
                    if (scnt == SLAST) begin
                        scnt_nxt  = '0;
                        state_nxt = IDLE;
                    end else begin
                        scnt_nxt = scnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Strobe and launch decrement are summed before clamping, so a
        // strobe at the rail is only discarded when the net change overflows.
        if (!zero) begin
            if (inc_up && !inc_dn)
                step = ONE;
            else if (inc_dn && !inc_up)
                step = -ONE;
        end
        if (launch)
            step = pending[CNT_W-1] ? (step + ONE) : (step - ONE);

        sum    = {{2{pending[CNT_W-1]}}, pending} + step;
        sat_hi = (sum > MAX_S);
        sat_lo = (sum < MIN_S);

        if (zero)
            pending_nxt = '0;
        else if (sat_hi)
            pending_nxt = MAX_S[CNT_W-1:0];
        else if (sat_lo)
            pending_nxt = MIN_S[CNT_W-1:0];
        else
            pending_nxt = sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            wcnt    <= '0;
            scnt    <= '0;
            pol     <= 1'b0;
            pending <= '0;
        end else begin
            state   <= state_nxt;
            wcnt    <= wcnt_nxt;
            scnt    <= scnt_nxt;
            pol     <= pol_nxt;
            pending <= pending_nxt;
        end
    end

`ifdef CDU_PULSE_OVF_EN
    always_ff @(posedge clk) begin
        if (rst || zero)
            ovf <= 1'b0;
        else if (sat_hi || sat_lo)
            ovf <= 1'b1;
    end
`endif

    assign CDUP = (state == PULSE) && pol;
    assign CDUM = (state == PULSE) && !pol;
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_cdu_pulse_gen.sv
// Directed bench for cdu_pulse_gen: a per-cycle vector table plus multi-cycle scenario sequences.
module tb_cdu_pulse_gen;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              slot_tick = 1'b0;
    logic              inc_up = 1'b0;
    logic              inc_dn = 1'b0;
    logic              zero = 1'b0;
    logic              CDUP;
    logic              CDUM;
    logic signed [7:0] pending;
    logic              busy;
`ifdef CDU_PULSE_OVF_EN
    logic              ovf;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    int up_hi, dn_hi, both_hi, up_rises, dn_rises;
    logic p_up, p_dn, up_rise, dn_rise;

    cdu_pulse_gen #(.CNT_W(8), .PULSE_W(4), .GAP_SLOTS(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .slot_tick (slot_tick),
        .inc_up    (inc_up),
        .inc_dn    (inc_dn),
        .zero      (zero),
        .CDUP      (CDUP),
        .CDUM      (CDUM),
        .pending   (pending),
        .busy      (busy)
`ifdef CDU_PULSE_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic r, t, u, d, z;
        int   pend;
        logic up, dn, bsy;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic clr_trk();
        up_hi = 0; dn_hi = 0; both_hi = 0; up_rises = 0; dn_rises = 0;
        p_up = CDUP; p_dn = CDUM;
    endtask

    // One clock: drive inputs, take the edge, sample 1 ns later, update pulse trackers.
    task automatic cyc(input logic t, input logic u, input logic d, input logic z, input logic r);
        slot_tick = t; inc_up = u; inc_dn = d; zero = z; rst = r;
        @(posedge clk);
        #1;
        slot_tick = 1'b0; inc_up = 1'b0; inc_dn = 1'b0; zero = 1'b0; rst = 1'b0;
        up_rise = CDUP && !p_up;
        dn_rise = CDUM && !p_dn;
        if (up_rise) up_rises++;
        if (dn_rise) dn_rises++;
        if (CDUP) up_hi++;
        if (CDUM) dn_hi++;
        if (CDUP && CDUM) both_hi++;
        p_up = CDUP; p_dn = CDUM;
    endtask

    vec_t vt[13];
    int   rise_at[3];
    int   rise_pend[3];
    int   k;

    initial begin
        //            r  t  u  d  z  pend up dn bsy
        vt[0]  = '{1, 0, 0, 0, 0,  0, 0, 0, 0};
        vt[1]  = '{0, 0, 1, 0, 0,  1, 0, 0, 0};
        vt[2]  = '{0, 0, 1, 0, 0,  2, 0, 0, 0};
        vt[3]  = '{0, 0, 1, 1, 0,  2, 0, 0, 0};
        vt[4]  = '{0, 0, 0, 0, 0,  2, 0, 0, 0};
        vt[5]  = '{0, 0, 0, 1, 0,  1, 0, 0, 0};
        vt[6]  = '{0, 1, 0, 0, 0,  0, 1, 0, 1};
        vt[7]  = '{0, 0, 0, 0, 0,  0, 1, 0, 1};
        vt[8]  = '{0, 1, 1, 0, 0,  1, 1, 0, 1};
        vt[9]  = '{0, 0, 0, 0, 0,  1, 1, 0, 1};
        vt[10] = '{0, 0, 0, 0, 0,  1, 0, 0, 1};
        vt[11] = '{0, 0, 1, 0, 1,  0, 0, 0, 1};
        vt[12] = '{0, 0, 0, 1, 0, -1, 0, 0, 1};

        @(posedge clk);
        #1;
        clr_trk();
        for (int i = 0; i < 13; i++) begin
            cyc(vt[i].t, vt[i].u, vt[i].d, vt[i].z, vt[i].r);
            chk($sformatf("vec%0d pending", i), int'(pending), vt[i].pend);
            chk($sformatf("vec%0d CDUP", i), int'(CDUP), int'(vt[i].up));
            chk($sformatf("vec%0d CDUM", i), int'(CDUM), int'(vt[i].dn));
            chk($sformatf("vec%0d busy", i), int'(busy), int'(vt[i].bsy));
        end

        // Scenario 1: three CDUP pulses, 8 slots apart.
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
        chk("s1 pending before", int'(pending), 3);
        clr_trk();
        for (int i = 0; i < 200; i++) begin
            cyc(i % 8 == 0, 0, 0, 0, 0);
            if (up_rise && up_rises <= 3) begin
                rise_at[up_rises-1] = i;
                rise_pend[up_rises-1] = int'(pending);
            end
        end
        chk("s1 rises", up_rises, 3);
        chk("s1 CDUP high cycles", up_hi, 12);
        chk("s1 CDUM high cycles", dn_hi, 0);
        if (up_rises >= 3) begin
            for (int j = 0; j < 3; j++)
                chk($sformatf("s1 pending at pulse %0d", j), rise_pend[j], 2 - j);
            chk("s1 spacing 1-2", rise_at[1] - rise_at[0], 64);
            chk("s1 spacing 2-3", rise_at[2] - rise_at[1], 64);
        end
        chk("s1 final busy", int'(busy), 0);

        // Scenario 2: simultaneous up/dn strobes cancel.
        cyc(0, 0, 0, 0, 1);
        clr_trk();
        for (int i = 0; i < 80; i++) cyc(i % 8 == 0, i < 10, i < 10, 0, 0);
        chk("s2 pending", int'(pending), 0);
        chk("s2 pulses", up_rises + dn_rises, 0);

        // Scenario 3: saturation in both directions.
        cyc(0, 0, 0, 0, 1);
        for (int i = 1; i <= 200; i++) begin
            cyc(0, 0, 1, 0, 0);
`ifdef CDU_PULSE_OVF_EN
            if (i == 127) chk("s3 ovf after 127", int'(ovf), 0);
            if (i == 128) chk("s3 ovf after 128", int'(ovf), 1);
`endif
        end
        chk("s3 pending neg sat", int'(pending), -127);
        cyc(0, 0, 0, 1, 0);
`ifdef CDU_PULSE_OVF_EN
        chk("s3 ovf cleared by zero", int'(ovf), 0);
`endif
        for (int i = 0; i < 300; i++) cyc(0, 1, 0, 0, 0);
        chk("s3 pending pos sat", int'(pending), 127);

        // Scenario 4: sign reversal during GAP.
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
        clr_trk();
        k = -1;
        for (int i = 0; i < 80; i++) begin
            cyc(i % 8 == 0, 0, (i >= 5 && i <= 9), 0, 0);
            if (i == 0) chk("s4 pending after launch", int'(pending), 2);
            if (i == 10) chk("s4 pending after dn", int'(pending), -3);
            if (dn_rise && k < 0) begin
                k = i;
                chk("s4 pending at CDUM launch", int'(pending), -2);
            end
        end
        chk("s4 CDUP high cycles", up_hi, 4);
        chk("s4 CDUM launch cycle", k, 64);
        chk("s4 CDUM rises", dn_rises, 1);
        chk("s4 overlap", both_hi, 0);

        // Scenario 5: zero during the pulse.
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0);
        clr_trk();
        for (int i = 0; i < 80; i++) cyc(i % 8 == 0, 0, 0, (i >= 1 && i <= 10), 0);
        chk("s5 CDUP high cycles", up_hi, 4);
        chk("s5 pulses", up_rises + dn_rises, 1);
        chk("s5 pending", int'(pending), 0);

        // Scenario 6: reset truncates a CDUM pulse.
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("s6 CDUM launched", int'(CDUM), 1);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 1, 0, 1, 1);
        chk("s6 CDUM after rst", int'(CDUM), 0);
        chk("s6 pending after rst", int'(pending), 0);
        chk("s6 busy after rst", int'(busy), 0);
        clr_trk();
        for (int i = 0; i < 80; i++) cyc(i % 8 == 0, 0, 0, 0, 0);
        chk("s6 pulses after rst", up_rises + dn_rises, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
